// File: rtl/int_sched_if.sv
// Scheduler bus: peripheral request lines and CPU handshake in, registered
// interrupt request, vector and status out.
interface int_sched_if #(
   parameter int NSRC = 4
) ();
   logic [NSRC-1:0] done;
   logic            status_bit;
   logic            int_ack;
   logic            int_done;
   logic            interrupt;
   logic [31:0]     int_addr;
   logic [2:0]      src_id;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] overrun;
   logic            busy;

   modport slave (
      input  done, status_bit, int_ack, int_done,
      output interrupt, int_addr, src_id, pending, overrun, busy
   );

   modport master (
      output done, status_bit, int_ack, int_done,
      input  interrupt, int_addr, src_id, pending, overrun, busy
   );
endinterface

// File: rtl/int_sched.sv
// Interrupt scheduler: captures peripheral request edges, arbitrates fixed-priority
// or round-robin, and hands one vectored interrupt at a time to the core.
module int_sched #(
   parameter int          NSRC       = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
   parameter bit          RR         = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   int_sched_if.slave   bus
);

   localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state_q, state_d;
   logic [NSRC-1:0] done_q, done_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] overrun_q, overrun_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [2:0]      src_id_q, src_id_d;
   logic [31:0]     int_addr_q, int_addr_d;
   logic            interrupt_q, interrupt_d;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] pending_kept;
   logic [3:0]      arb;

   // Returns {found, id}. Round-robin starts one past the last serviced source.
   function automatic logic [3:0] pick(input logic [NSRC-1:0] p,
                                       input logic [IDW-1:0]  ptr);
      logic       found;
      logic [2:0] id;
      int         idx;
      found = 1'b0;
      id    = 3'd0;
      for (int k = 1; k <= NSRC; k++) begin
         idx = RR ? (int'(ptr) + k) % NSRC : k - 1;
         if (!found && p[IDW'(idx)]) begin
            found = 1'b1;
            id    = 3'(idx);
         end
      end
      return {found, id};
   endfunction

   always_comb begin
      state_d     = state_q;
      interrupt_d = interrupt_q;
      src_id_d    = src_id_q;
      int_addr_d  = int_addr_q;
      ptr_d       = ptr_q;
      clr         = '0;
      done_d      = bus.done;
      rise        = bus.done & ~done_q;
      arb         = pick(pending_q, ptr_q);

      case (state_q)
         IDLE: begin
            if (arb[3] && !bus.status_bit) begin
               src_id_d    = arb[2:0];
               int_addr_d  = VEC_BASE + 32'(arb[2:0]) * VEC_STRIDE;
               interrupt_d = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            // Ack beats a simultaneous mask: the CPU has already taken the vector.
            if (bus.int_ack) begin
               clr[src_id_q[IDW-1:0]] = 1'b1;
               interrupt_d = 1'b0;
               ptr_d       = src_id_q[IDW-1:0];
               state_d     = SERVICE;
            end else if (bus.status_bit) begin
               interrupt_d = 1'b0;
               state_d     = IDLE;
            end
         end
         SERVICE: begin
            if (bus.int_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A fresh edge in the ack cycle is a new event, so it re-sets pending
      // without counting as an overrun of the event just taken.
      pending_kept = pending_q & ~clr;
      pending_d    = pending_kept | rise;
      overrun_d    = (overrun_q & ~clr) | (rise & pending_kept);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         done_q      <= '0;
         pending_q   <= '0;
         overrun_q   <= '0;
         ptr_q       <= IDW'(NSRC - 1);
         src_id_q    <= 3'd0;
         int_addr_q  <= 32'd0;
         interrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         ptr_q       <= ptr_d;
         src_id_q    <= src_id_d;
         int_addr_q  <= int_addr_d;
         interrupt_q <= interrupt_d;
      end
   end

   assign bus.interrupt = interrupt_q;
   assign bus.int_addr  = int_addr_q;
   assign bus.src_id    = src_id_q;
   assign bus.pending   = pending_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_int_sched.sv
// Directed bench: one fixed-priority and one round-robin scheduler driven by
// hand-written steps with hand-computed expected outputs.
module tb_int_sched;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   int_sched_if #(.NSRC(4)) a ();
   int_sched_if #(.NSRC(4)) b ();

   int_sched #(.NSRC(4), .RR(1'b0)) u_fp (.clk(clk), .reset(reset), .bus(a));
   int_sched #(.NSRC(4), .RR(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      a.done = '0; a.status_bit = 1'b0; a.int_ack = 1'b0; a.int_done = 1'b0;
      b.done = '0; b.status_bit = 1'b0; b.int_ack = 1'b0; b.int_done = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_interrupt", 32'(a.interrupt), 32'd0);
      chk("rst_addr",      a.int_addr,       32'd0);
      chk("rst_src",       32'(a.src_id),    32'd0);
      chk("rst_pending",   32'(a.pending),   32'd0);
      chk("rst_overrun",   32'(a.overrun),   32'd0);
      chk("rst_busy",      32'(a.busy),      32'd0);

      // single source 2, two-cycle latency
      a.done = 4'b0100; tick(); a.done = '0;
      chk("t1_pending", 32'(a.pending), 32'h4);
      chk("t1_int_early", 32'(a.interrupt), 32'd0);
      tick();
      chk("t1_int", 32'(a.interrupt), 32'd1);
      chk("t1_addr", a.int_addr, 32'h120);
      chk("t1_src", 32'(a.src_id), 32'd2);
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      chk("t1_ack_pending", 32'(a.pending), 32'h0);
      chk("t1_ack_int", 32'(a.interrupt), 32'd0);
      chk("t1_ack_busy", 32'(a.busy), 32'd1);
      tick();
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;
      chk("t1_done_busy", 32'(a.busy), 32'd0);
      chk("t1_hold_addr", a.int_addr, 32'h120);

      // fixed priority: 3 and 1 together
      a.done = 4'b1010; tick(); a.done = '0;
      chk("t2_pending", 32'(a.pending), 32'ha);
      tick();
      chk("t2_src1", 32'(a.src_id), 32'd1);
      chk("t2_addr1", a.int_addr, 32'h110);
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      chk("t2_pend_after", 32'(a.pending), 32'h8);
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;
      chk("t2_gap", 32'(a.interrupt), 32'd0);
      tick();
      chk("t2_int3", 32'(a.interrupt), 32'd1);
      chk("t2_src3", 32'(a.src_id), 32'd3);
      chk("t2_addr3", a.int_addr, 32'h130);
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;

      // masking and withdrawal
      a.status_bit = 1'b1;
      a.done = 4'b0001; tick(); a.done = '0;
      tick(); tick();
      chk("t3_pend_masked", 32'(a.pending), 32'h1);
      chk("t3_int_masked", 32'(a.interrupt), 32'd0);
      a.status_bit = 1'b0; tick();
      chk("t3_int_unmask", 32'(a.interrupt), 32'd1);
      a.status_bit = 1'b1; tick();
      chk("t3_withdraw_int", 32'(a.interrupt), 32'd0);
      chk("t3_withdraw_pend", 32'(a.pending), 32'h1);
      chk("t3_withdraw_busy", 32'(a.busy), 32'd0);
      a.status_bit = 1'b0; tick();
      chk("t3_reissue", 32'(a.interrupt), 32'd1);
      a.int_ack = 1'b1; a.status_bit = 1'b1; tick(); a.int_ack = 1'b0; a.status_bit = 1'b0;
      chk("t3_ack_wins_pend", 32'(a.pending), 32'h0);
      chk("t3_ack_wins_busy", 32'(a.busy), 32'd1);
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;

      // overrun and coalescing
      a.done = 4'b0010; tick(); a.done = '0; tick();
      a.done = 4'b0010; tick(); a.done = '0;
      chk("t4_overrun", 32'(a.overrun), 32'h2);
      chk("t4_pending", 32'(a.pending), 32'h2);
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      chk("t4_ov_clear", 32'(a.overrun), 32'h0);
      chk("t4_pend_clear", 32'(a.pending), 32'h0);
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;
      tick();
      chk("t4_one_service", 32'(a.interrupt), 32'd0);
      a.done = 4'b0010; tick(); a.done = '0; tick();
      a.done = 4'b0010; a.int_ack = 1'b1; tick(); a.done = '0; a.int_ack = 1'b0;
      chk("t4_set_wins", 32'(a.pending), 32'h2);
      chk("t4_set_wins_busy", 32'(a.busy), 32'd1);
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;
      tick();
      chk("t4_reserve_src", 32'(a.src_id), 32'd1);
      chk("t4_reserve_int", 32'(a.interrupt), 32'd1);
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      a.int_done = 1'b1; tick(); a.int_done = 1'b0;

      // round-robin order 0,1,2,3 with re-raises
      b.done = 4'b1111; tick(); b.done = '0;
      chk("rr_pending", 32'(b.pending), 32'hf);
      tick();
      chk("rr_src0", 32'(b.src_id), 32'd0);
      chk("rr_addr0", b.int_addr, 32'h100);
      b.int_ack = 1'b1; tick(); b.int_ack = 1'b0;
      b.done = 4'b0001; tick(); b.done = '0;
      chk("rr_repend0", 32'(b.pending), 32'hf);
      b.int_done = 1'b1; tick(); b.int_done = 1'b0; tick();
      chk("rr_src1", 32'(b.src_id), 32'd1);
      chk("rr_addr1", b.int_addr, 32'h110);
      b.int_ack = 1'b1; tick(); b.int_ack = 1'b0;
      b.int_done = 1'b1; tick(); b.int_done = 1'b0; tick();
      chk("rr_src2", 32'(b.src_id), 32'd2);
      chk("rr_addr2", b.int_addr, 32'h120);
      b.int_ack = 1'b1; tick(); b.int_ack = 1'b0;
      b.int_done = 1'b1; tick(); b.int_done = 1'b0; tick();
      chk("rr_src3", 32'(b.src_id), 32'd3);
      chk("rr_addr3", b.int_addr, 32'h130);
      b.int_ack = 1'b1; tick(); b.int_ack = 1'b0;
      b.done = 4'b0001; tick(); b.done = '0;
      chk("rr_ov0", 32'(b.overrun), 32'h1);
      b.int_done = 1'b1; tick(); b.int_done = 1'b0; tick();
      chk("rr_src0_again", 32'(b.src_id), 32'd0);
      chk("rr_addr0_again", b.int_addr, 32'h100);
      b.int_ack = 1'b1; tick(); b.int_ack = 1'b0;
      chk("rr_final_pend", 32'(b.pending), 32'h0);
      b.int_done = 1'b1; tick(); b.int_done = 1'b0;

      // asynchronous reset during SERVICE
      a.done = 4'b1010; tick(); a.done = '0; tick();
      a.int_ack = 1'b1; tick(); a.int_ack = 1'b0;
      a.done = 4'b0010; tick(); a.done = '0;
      chk("t6_pend_pre", 32'(a.pending), 32'ha);
      chk("t6_busy_pre", 32'(a.busy), 32'd1);
      #2;
      reset = 1'b1;
      a.done = 4'b0001;
      #1;
      chk("t6_async_pend", 32'(a.pending), 32'h0);
      chk("t6_async_busy", 32'(a.busy), 32'd0);
      chk("t6_async_addr", a.int_addr, 32'd0);
      chk("t6_async_src", 32'(a.src_id), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("t6_edge_after_rst", 32'(a.pending), 32'h1);
      a.done = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
